// File: rtl/btn_pkg.sv
// Shared constants and types for the push-button conditioner.
//   BTN_* : bit index of each button in the btn_* buses
//   rpt_state_e : per-channel auto-repeat state encoding
//   cnt_width / max_u : counter sizing helpers
package btn_pkg;

  localparam int unsigned BTN_UP    = 0;
  localparam int unsigned BTN_DOWN  = 1;
  localparam int unsigned BTN_LEFT  = 2;
  localparam int unsigned BTN_RIGHT = 3;
  localparam int unsigned BTN_MID   = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } rpt_state_e;

  // Counter width able to hold n with one spare bit of headroom.
  function automatic int unsigned cnt_width(input int unsigned n);
    return int'($clog2(n)) + 1;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-flop synchroniser, debounce filter, press/release
// pulses and (with BTN_AUTO_REPEAT_EN defined) hold-to-auto-repeat.
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   btn_raw       raw asynchronous pin
//   btn_level     debounced level
//   btn_press     1-cycle pulse on accepted press and each auto-repeat
//   btn_release   1-cycle pulse on accepted release
//   btn_long      high while held >= REPEAT_DELAY (0 without BTN_AUTO_REPEAT_EN)
module btn_channel
  import btn_pkg::*;
#(
  parameter int unsigned DEB_CYCLES   = 1_000_000,
  parameter int unsigned REPEAT_DELAY = 50_000_000,
  parameter int unsigned REPEAT_RATE  = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_long
);

  localparam int unsigned DEB_W = cnt_width(DEB_CYCLES);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             rise_c, fall_c;

`ifdef BTN_AUTO_REPEAT_EN
  localparam int unsigned RPT_W = cnt_width(max_u(REPEAT_DELAY, REPEAT_RATE));

  rpt_state_e       state_q, state_d;
  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic             long_q, long_d;
`else
  logic unused_rpt_cfg_c;
  assign unused_rpt_cfg_c = ^{REPEAT_DELAY, REPEAT_RATE};
`endif

  // Debounce, pulse generation and repeat next-state logic.
  always_comb begin
    level_d   = level_q;
    deb_cnt_d = '0;
    rise_c    = 1'b0;
    fall_c    = 1'b0;
    press_d   = 1'b0;

    // Count consecutive samples that disagree with the accepted level.
    if (sync2_q != level_q) begin
      if (deb_cnt_q == DEB_W'(DEB_CYCLES - 1)) begin
        level_d = ~level_q;
        rise_c  = ~level_q;
        fall_c  = level_q;
      end else if (deb_cnt_q != {DEB_W{1'b1}}) begin
        deb_cnt_d = deb_cnt_q + DEB_W'(1);
      end else begin
        deb_cnt_d = deb_cnt_q;
      end
    end

    release_d = fall_c;

`ifdef BTN_AUTO_REPEAT_EN
    state_d   = state_q;
    rpt_cnt_d = rpt_cnt_q;
    long_d    = long_q;

    case (state_q)
      IDLE: begin
        if (rise_c) begin
          state_d   = HOLD;
          rpt_cnt_d = '0;
          press_d   = 1'b1;
        end
      end
      HOLD: begin
        // Level fall wins over a coincident delay expiry.
        if (fall_c) begin
          state_d   = IDLE;
          rpt_cnt_d = '0;
          long_d    = 1'b0;
        end else if (rpt_cnt_q == RPT_W'(REPEAT_DELAY - 1)) begin
          state_d   = REPEAT;
          rpt_cnt_d = '0;
          long_d    = 1'b1;
          press_d   = 1'b1;
        end else if (rpt_cnt_q != {RPT_W{1'b1}}) begin
          rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
        end
      end
      REPEAT: begin
        if (fall_c) begin
          state_d   = IDLE;
          rpt_cnt_d = '0;
          long_d    = 1'b0;
        end else if (rpt_cnt_q == RPT_W'(REPEAT_RATE - 1)) begin
          rpt_cnt_d = '0;
          press_d   = 1'b1;
        end else if (rpt_cnt_q != {RPT_W{1'b1}}) begin
          rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        rpt_cnt_d = '0;
        long_d    = 1'b0;
      end
    endcase
`else
    press_d = rise_c;
`endif
  end

  // State registers; reset silently discards any held button.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      level_q   <= 1'b0;
      deb_cnt_q <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
      state_q   <= IDLE;
      rpt_cnt_q <= '0;
      long_q    <= 1'b0;
`endif
    end else begin
      sync1_q   <= btn_raw;
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      deb_cnt_q <= deb_cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
`ifdef BTN_AUTO_REPEAT_EN
      state_q   <= state_d;
      rpt_cnt_q <= rpt_cnt_d;
      long_q    <= long_d;
`endif
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
`ifdef BTN_AUTO_REPEAT_EN
  assign btn_long    = long_q;
`else
  assign btn_long    = 1'b0;
`endif

endmodule

// File: rtl/button_conditioner.sv
// Push-button front end: N_BTN independent conditioned channels.
// Bit map of every bus: {middle,right,left,down,up}.
// Auto-repeat is built only when BTN_AUTO_REPEAT_EN is defined.
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   btn_raw       raw asynchronous, bouncing pins
//   btn_level     debounced levels
//   btn_press     1-cycle pulses on accepted press / auto-repeat
//   btn_release   1-cycle pulses on accepted release
//   btn_long      high while held >= REPEAT_DELAY
module button_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned N_BTN        = 5,
  parameter int unsigned DEB_CYCLES   = 1_000_000,
  parameter int unsigned REPEAT_DELAY = 50_000_000,
  parameter int unsigned REPEAT_RATE  = 10_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_long
);

  // One fully independent channel per button.
  for (genvar i = 0; i < int'(N_BTN); i++) begin : g_ch
    btn_channel #(
      .DEB_CYCLES  (DEB_CYCLES),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE (REPEAT_RATE)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .btn_raw    (btn_raw[i]),
      .btn_level  (btn_level[i]),
      .btn_press  (btn_press[i]),
      .btn_release(btn_release[i]),
      .btn_long   (btn_long[i])
    );
  end

endmodule
